// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with load alignment/extension, result select and
// retired-instruction counter feeding the register-file write port.
module writeback_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Stall_W,
    input  logic             Flush_W,
    input  logic             Valid_M,
    input  logic [XLEN-1:0]  ALUResult_M,
    input  logic [XLEN-1:0]  ReadData_M,
    input  logic [XLEN-1:0]  PCPlus4_M,
    input  logic [XLEN-1:0]  ImmExt_M,
    input  logic [1:0]       ResultSrc_M,
    input  logic [2:0]       Funct3_M,
    input  logic             RegWrite_M,
    input  logic [4:0]       Rd_M,
    output logic [XLEN-1:0]  Result_W,
    output logic [4:0]       Rd_W,
    output logic             RegWrite_W,
    output logic             Valid_W,
    output logic [CNT_W-1:0] InstRet_W
);

    logic             valid_reg;
    logic             regwrite_reg;
    logic [4:0]       rd_reg;
    logic [XLEN-1:0]  alu_reg;
    logic [XLEN-1:0]  rdata_reg;
    logic [XLEN-1:0]  pc4_reg;
    logic [XLEN-1:0]  imm_reg;
    logic [1:0]       src_reg;
    logic [2:0]       funct3_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
            rd_reg       <= '0;
            alu_reg      <= '0;
            rdata_reg    <= '0;
            pc4_reg      <= '0;
            imm_reg      <= '0;
            src_reg      <= '0;
            funct3_reg   <= '0;
            cnt_reg      <= '0;
        end else if (Flush_W) begin
            // Bubble: only the qualifiers matter, payload fields simply hold.
            valid_reg    <= 1'b0;
            regwrite_reg <= 1'b0;
        end else if (!Stall_W) begin
            valid_reg    <= Valid_M;
            regwrite_reg <= RegWrite_M;
            rd_reg       <= Rd_M;
            alu_reg      <= ALUResult_M;
            rdata_reg    <= ReadData_M;
            pc4_reg      <= PCPlus4_M;
            imm_reg      <= ImmExt_M;
            src_reg      <= ResultSrc_M;
            funct3_reg   <= Funct3_M;
            if (Valid_M)
                cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Byte offset within the word; 32-bit datapaths only have four lanes.
    logic [2:0] off_raw;
    generate
        if (XLEN == 64) begin : g_off64
            assign off_raw = alu_reg[2:0];
        end else begin : g_off32
            assign off_raw = {1'b0, alu_reg[1:0]};
        end
    endgenerate

    logic [2:0]      off_aligned;
    logic [63:0]     rdata_wide;
    logic [63:0]     shifted;
    logic [63:0]     ext_wide;
    logic [XLEN-1:0] load_data;

    // Extension is done at 64 bits and truncated, so on XLEN=32 the word and
    // doubleword codes collapse to the unmodified word.
    always_comb begin
        off_aligned = off_raw;
        case (funct3_reg[1:0])
            2'b01:   off_aligned = {off_raw[2:1], 1'b0};
            2'b10:   off_aligned = {off_raw[2], 2'b00};
            2'b11:   off_aligned = 3'b000;
            default: off_aligned = off_raw;
        endcase
        rdata_wide = 64'(rdata_reg);
        shifted    = rdata_wide >> {off_aligned, 3'b000};
        case (funct3_reg)
            3'b000:  ext_wide = {{56{shifted[7]}}, shifted[7:0]};
            3'b100:  ext_wide = {56'd0, shifted[7:0]};
            3'b001:  ext_wide = {{48{shifted[15]}}, shifted[15:0]};
            3'b101:  ext_wide = {48'd0, shifted[15:0]};
            3'b010:  ext_wide = {{32{shifted[31]}}, shifted[31:0]};
            3'b110:  ext_wide = {32'd0, shifted[31:0]};
            default: ext_wide = shifted;
        endcase
        load_data = ext_wide[XLEN-1:0];
    end

    always_comb begin
        case (src_reg)
            2'b00:   Result_W = alu_reg;
            2'b01:   Result_W = load_data;
            2'b10:   Result_W = pc4_reg;
            default: Result_W = imm_reg;
        endcase
    end

    assign Rd_W       = rd_reg;
    assign Valid_W    = valid_reg;
    assign RegWrite_W = regwrite_reg & valid_reg & (rd_reg != 5'd0);
    assign InstRet_W  = cnt_reg;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: 64-bit instance plus a CNT_W=4 instance
// sharing the same stimulus to observe counter wrap.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Stall_W = 1'b0;
    logic        Flush_W = 1'b0;
    logic        Valid_M = 1'b0;
    logic [63:0] ALUResult_M = '0;
    logic [63:0] ReadData_M = '0;
    logic [63:0] PCPlus4_M = '0;
    logic [63:0] ImmExt_M = '0;
    logic [1:0]  ResultSrc_M = '0;
    logic [2:0]  Funct3_M = '0;
    logic        RegWrite_M = 1'b0;
    logic [4:0]  Rd_M = '0;

    logic [63:0] Result_W, Result_W4;
    logic [4:0]  Rd_W, Rd_W4;
    logic        RegWrite_W, RegWrite_W4;
    logic        Valid_W, Valid_W4;
    logic [63:0] InstRet_W;
    logic [3:0]  InstRet_W4;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_cnt = '0;

    localparam logic [63:0] RDATA = 64'h8899_AABB_CCDD_EEFF;

    writeback_stage #(.XLEN(64), .CNT_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .Stall_W(Stall_W), .Flush_W(Flush_W),
        .Valid_M(Valid_M), .ALUResult_M(ALUResult_M), .ReadData_M(ReadData_M),
        .PCPlus4_M(PCPlus4_M), .ImmExt_M(ImmExt_M), .ResultSrc_M(ResultSrc_M),
        .Funct3_M(Funct3_M), .RegWrite_M(RegWrite_M), .Rd_M(Rd_M),
        .Result_W(Result_W), .Rd_W(Rd_W), .RegWrite_W(RegWrite_W),
        .Valid_W(Valid_W), .InstRet_W(InstRet_W)
    );

    writeback_stage #(.XLEN(64), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Stall_W(Stall_W), .Flush_W(Flush_W),
        .Valid_M(Valid_M), .ALUResult_M(ALUResult_M), .ReadData_M(ReadData_M),
        .PCPlus4_M(PCPlus4_M), .ImmExt_M(ImmExt_M), .ResultSrc_M(ResultSrc_M),
        .Funct3_M(Funct3_M), .RegWrite_M(RegWrite_M), .Rd_M(Rd_M),
        .Result_W(Result_W4), .Rd_W(Rd_W4), .RegWrite_W(RegWrite_W4),
        .Valid_W(Valid_W4), .InstRet_W(InstRet_W4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%016h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] src, input logic [2:0] f3, input logic [63:0] alu,
                         input logic [4:0] rd, input logic rw);
        Valid_M     = 1'b1;
        ResultSrc_M = src;
        Funct3_M    = f3;
        ALUResult_M = alu;
        Rd_M        = rd;
        RegWrite_M  = rw;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] exp);
        issue(2'b01, f3, addr, 5'd6, 1'b1);
        ReadData_M = RDATA;
        step();
        exp_cnt++;
        check(tag, Result_W, exp);
        check({tag, "_cnt"}, InstRet_W, exp_cnt);
    endtask

    initial begin
        PCPlus4_M = 64'h1004;
        ImmExt_M  = 64'h1234_5000;
        #3;
        check("rst_result", Result_W, 64'd0);
        check("rst_rd", 64'(Rd_W), 64'd0);
        check("rst_regwrite", 64'(RegWrite_W), 64'd0);
        check("rst_valid", 64'(Valid_W), 64'd0);
        check("rst_instret", InstRet_W, 64'd0);
        rst_n = 1'b1;

        // ALU result, one-cycle latency
        issue(2'b00, 3'b000, 64'hAAAA_AAAA_AAAA_AAAA, 5'd5, 1'b1);
        step();
        exp_cnt++;
        check("alu_result", Result_W, 64'hAAAA_AAAA_AAAA_AAAA);
        check("alu_rd", 64'(Rd_W), 64'd5);
        check("alu_regwrite", 64'(RegWrite_W), 64'd1);
        check("alu_valid", 64'(Valid_W), 64'd1);
        check("alu_instret", InstRet_W, exp_cnt);

        do_load("lb_3",  3'b000, 64'h1003, 64'hFFFF_FFFF_FFFF_FFCC);
        do_load("lbu_3", 3'b100, 64'h1003, 64'h0000_0000_0000_00CC);
        do_load("lh_6",  3'b001, 64'h1006, 64'hFFFF_FFFF_FFFF_8899);
        do_load("lh_7",  3'b001, 64'h1007, 64'hFFFF_FFFF_FFFF_8899);
        do_load("lhu_2", 3'b101, 64'h1002, 64'h0000_0000_0000_CCDD);
        do_load("lw_4",  3'b010, 64'h1004, 64'hFFFF_FFFF_8899_AABB);
        do_load("lw_5",  3'b010, 64'h1005, 64'hFFFF_FFFF_8899_AABB);
        do_load("lwu_0", 3'b110, 64'h1000, 64'h0000_0000_CCDD_EEFF);
        do_load("lwu_4", 3'b110, 64'h1004, 64'h0000_0000_8899_AABB);
        do_load("ld_5",  3'b011, 64'h1005, RDATA);
        do_load("f111",  3'b111, 64'h1002, RDATA);

        issue(2'b10, 3'b000, 64'h55, 5'd1, 1'b1);
        step();
        exp_cnt++;
        check("pc4_result", Result_W, 64'h1004);

        issue(2'b11, 3'b000, 64'h55, 5'd2, 1'b1);
        step();
        exp_cnt++;
        check("imm_result", Result_W, 64'h1234_5000);

        // Write to x0 is suppressed but still retires
        issue(2'b00, 3'b000, 64'h99, 5'd0, 1'b1);
        step();
        exp_cnt++;
        check("x0_regwrite", 64'(RegWrite_W), 64'd0);
        check("x0_valid", 64'(Valid_W), 64'd1);
        check("x0_instret", InstRet_W, exp_cnt);

        // RegWrite_M low: no write, still counted
        issue(2'b00, 3'b000, 64'h98, 5'd3, 1'b0);
        step();
        exp_cnt++;
        check("store_regwrite", 64'(RegWrite_W), 64'd0);
        check("store_instret", InstRet_W, exp_cnt);

        // Invalid slot is not counted
        issue(2'b00, 3'b000, 64'h97, 5'd3, 1'b1);
        Valid_M = 1'b0;
        step();
        check("bubble_valid", 64'(Valid_W), 64'd0);
        check("bubble_regwrite", 64'(RegWrite_W), 64'd0);
        check("bubble_instret", InstRet_W, exp_cnt);

        // Stall for three cycles with changing M inputs
        issue(2'b00, 3'b000, 64'h55, 5'd7, 1'b1);
        step();
        exp_cnt++;
        Stall_W = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issue(2'b10, 3'b001, 64'(i + 100), 5'(i + 10), 1'b1);
            step();
            check($sformatf("stall%0d_result", i), Result_W, 64'h55);
            check($sformatf("stall%0d_rd", i), 64'(Rd_W), 64'd7);
            check($sformatf("stall%0d_instret", i), InstRet_W, exp_cnt);
        end
        Stall_W = 1'b0;
        issue(2'b00, 3'b000, 64'h66, 5'd8, 1'b1);
        step();
        exp_cnt++;
        check("unstall_result", Result_W, 64'h66);
        check("unstall_instret", InstRet_W, exp_cnt);

        // Flush and Stall together: flush wins, no count
        Flush_W = 1'b1;
        Stall_W = 1'b1;
        issue(2'b00, 3'b000, 64'h67, 5'd9, 1'b1);
        step();
        check("flushstall_valid", 64'(Valid_W), 64'd0);
        check("flushstall_regwrite", 64'(RegWrite_W), 64'd0);
        check("flushstall_instret", InstRet_W, exp_cnt);
        Stall_W = 1'b0;
        step();
        check("flush_valid", 64'(Valid_W), 64'd0);
        check("flush_instret", InstRet_W, exp_cnt);
        Flush_W = 1'b0;

        // Asynchronous reset in the middle of a stall
        issue(2'b10, 3'b000, 64'h77, 5'd9, 1'b1);
        step();
        exp_cnt++;
        check("prerst_valid", 64'(Valid_W), 64'd1);
        check("prerst_instret", InstRet_W, exp_cnt);
        Stall_W = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_result", Result_W, 64'd0);
        check("arst_rd", 64'(Rd_W), 64'd0);
        check("arst_regwrite", 64'(RegWrite_W), 64'd0);
        check("arst_valid", 64'(Valid_W), 64'd0);
        check("arst_instret", InstRet_W, 64'd0);
        check("arst_instret4", 64'(InstRet_W4), 64'd0);
        exp_cnt = '0;
        Stall_W = 1'b0;
        rst_n = 1'b1;

        // Retire 17 instructions: the 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            issue(2'b00, 3'b000, 64'(i), 5'd4, 1'b1);
            step();
            exp_cnt++;
        end
        check("wrap_instret64", InstRet_W, 64'd17);
        check("wrap_instret4", 64'(InstRet_W4), 64'd1);
        check("wrap_result4", Result_W4, 64'd16);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised successor to the combinational writeback mux.
- Contains the MEM/WB pipeline register with stall/flush, load-data alignment and sign/zero extension, a 4-way result select, and a retired-instruction counter.
- Sits between the memory stage and the register file write port.
- Its outputs also feed the hazard/forwarding unit.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Stall_W  input  1  hold the MEM/WB register.
- Flush_W  input  1  insert a bubble into W.
- Valid_M  input  1  M-stage slot holds a real instruction.
- ALUResult_M  input  XLEN  ALU result / memory address.
- ReadData_M  input  XLEN  naturally aligned XLEN-bit word read from data memory.
- PCPlus4_M  input  XLEN  PC+4 (JAL/JALR link).
- ImmExt_M  input  XLEN  extended immediate (LUI).
- ResultSrc_M  input  2  00 ALU, 01 load, 10 PC+4, 11 ImmExt.
- Funct3_M  input  3  load size/sign code.
- RegWrite_M  input  1  instruction writes rd.
- Rd_M  input  5  destination register.
- Result_W  output  XLEN  register-file write data.
- Rd_W  output  5  register-file write address.
- RegWrite_W  output  1  register-file write enable.
- Valid_W  output  1  W slot valid.
- InstRet_W  output  CNT_W  retired-instruction count.

Behaviour:
- Reset: rst_n low clears all MEM/WB register fields and InstRet_W to 0, asynchronously.
  - Result_W = 0, Rd_W = 0, RegWrite_W = 0, Valid_W = 0 during reset.
  - Reset mid-stream discards the in-flight W instruction; it is not counted.
- Register update, evaluated at each rising clk edge, in priority order:
  - Flush_W = 1: Valid and RegWrite fields cleared; other fields don't-care. Flush wins over Stall.
  - Else Stall_W = 1: all fields hold.
  - Else: all M-stage fields load.
- Latency: one cycle from M inputs to W outputs. Result_W is combinational from registered fields.
- Write enable: RegWrite_W = registered RegWrite AND registered Valid AND (Rd_W != 0). A write to x0 is never asserted.
- Load extraction, applied only when ResultSrc = 01, using the registered data and address:
  - Byte offset off = ALUResult[2:0] when XLEN = 64, ALUResult[1:0] when XLEN = 32.
  - Offset is forced to natural alignment for the access size (low bits cleared). No misalign trap in this block.
  - 000 LB: sign-extend byte at off.
  - 100 LBU: zero-extend byte at off.
  - 001 LH: sign-extend half at off.
  - 101 LHU: zero-extend half at off.
  - 010 LW: sign-extend word at off.
  - 110 LWU: zero-extend word at off.
  - 011 LD: full XLEN.
  - 111: full XLEN.
  - When XLEN = 32, 110 and 011 return the full word unmodified.
- Result select: 00 ALUResult, 01 extracted load, 10 PCPlus4, 11 ImmExt.
- Retire counter:
  - Increments by 1 on each edge where the register loads with Valid_M = 1, i.e. Stall_W = 0 and Flush_W = 0.
  - A stalled instruction is counted once only.
  - Wraps modulo 2^CNT_W with no saturation.
  - Counts valid instructions regardless of RegWrite (stores and branches count).
- Simultaneous events: Flush_W and Stall_W both high means flush; the counter does not increment.

Test Plan:
- Reset release, then ALU op: Valid_M = 1, ResultSrc = 00, ALUResult = 0xAAAA_AAAA_AAAA_AAAA, Rd = 5, RegWrite = 1.
  - One cycle later: Result_W = 0xAAAA_AAAA_AAAA_AAAA, Rd_W = 5, RegWrite_W = 1, InstRet_W = 1.
- Loads with ReadData = 0x8899_AABB_CCDD_EEFF:
  - LB, addr = ...3 -> 0xFFFF_FFFF_FFFF_FFCC.
  - LBU, addr = ...3 -> 0x0000_0000_0000_00CC.
  - LH, addr = ...6 -> 0xFFFF_FFFF_FFFF_8899.
  - LW, addr = ...4 -> 0xFFFF_FFFF_8899_AABB.
  - LWU, addr = ...0 -> 0x0000_0000_CCDD_EEFF.
  - LD -> full word.
- ResultSrc = 10 with PCPlus4 = 0x1004 -> Result_W = 0x1004.
- ResultSrc = 11 with ImmExt = 0x12345000 -> Result_W = 0x12345000.
- Rd_M = 0 with RegWrite_M = 1 -> RegWrite_W = 0 while Valid_W = 1; InstRet_W still increments.
- Stall for 3 cycles with changing M inputs -> W outputs frozen and InstRet_W unchanged during the stall.
- Flush and Stall asserted together -> next cycle Valid_W = 0, RegWrite_W = 0, no count.
- CNT_W = 4: retire 17 instructions -> InstRet_W = 1 (wrap).
- Assert rst_n low mid-stall -> all outputs 0 immediately, before the next clk edge.
